// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: serial transmitter that pops words from a first-word-fall-through FIFO
module uart_tx_fifo #(
  parameter int dat_width = 8,
  parameter int clk_div = 434,
  parameter int parity = 0,
  parameter int stop_bits = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 fifo_empty,
  input  logic [dat_width-1:0] fifo_data,
  output logic                 fifo_rd,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);
  localparam int bw = $clog2(dat_width + 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PAR = 3'd3, STOP = 3'd4;
  localparam logic [bw-1:0] last_bit = bw'(dat_width - 1);
  localparam logic [bw-1:0] last_stop = bw'(stop_bits - 1);
  logic [2:0] state;
  logic [15:0] baud_cnt;
  logic [bw-1:0] bit_cnt;
  logic [dat_width-1:0] shreg;
  logic par_bit;
  logic wrap;
  assign wrap = baud_cnt == 16'(clk_div - 1);
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      par_bit <= 1'b0;
      tx <= 1'b1;
      fifo_rd <= 1'b0;
      busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      fifo_rd <= 1'b0;
      tx_done <= state == STOP && bit_cnt == last_stop && baud_cnt == 16'(clk_div - 2);
      baud_cnt <= (state == IDLE || wrap) ? '0 : baud_cnt + 16'd1;
      case (state)
        IDLE: if (en && !fifo_empty) begin
          state <= START;
          tx <= 1'b0;
          busy <= 1'b1;
          fifo_rd <= 1'b1;
          shreg <= fifo_data;
          par_bit <= (^fifo_data) ^ (parity == 2);
          bit_cnt <= '0;
        end
        START: if (wrap) begin
          state <= DATA;
          tx <= shreg[0];
          shreg <= shreg >> 1;
        end
        DATA: if (wrap) begin
          if (bit_cnt == last_bit) begin
            bit_cnt <= '0;
            state <= parity != 0 ? PAR : STOP;
            tx <= parity != 0 ? par_bit : 1'b1;
          end else begin
            bit_cnt <= bit_cnt + bw'(1);
            tx <= shreg[0];
            shreg <= shreg >> 1;
          end
        end
        PAR: if (wrap) begin
          state <= STOP;
          tx <= 1'b1;
        end
        STOP: if (wrap) begin
          if (bit_cnt == last_stop) begin
            state <= IDLE;
            busy <= 1'b0;
            bit_cnt <= '0;
          end else bit_cnt <= bit_cnt + bw'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for three transmitter configurations fed by modelled FIFOs
module tb_uart_tx_fifo;
  logic clk, reset, en;
  logic [2:0] empty_v, rd_v, tx_v, busy_v, done_v;
  logic [7:0] data_v [3];
  logic [7:0] fq0[$], fq1[$], fq2[$];
  logic [11:0] eq0[$], eq1[$], eq2[$];
  int tests = 0, fails = 0, cyc = 0;
  int rd_cnt [3] = '{0, 0, 0};
  int rd_t0[$];

  uart_tx_fifo #(.dat_width(8), .clk_div(4), .parity(0), .stop_bits(1)) d0 (.clk(clk), .reset(reset), .en(en),
    .fifo_empty(empty_v[0]), .fifo_data(data_v[0]), .fifo_rd(rd_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]));
  uart_tx_fifo #(.dat_width(8), .clk_div(4), .parity(1), .stop_bits(1)) d1 (.clk(clk), .reset(reset), .en(en),
    .fifo_empty(empty_v[1]), .fifo_data(data_v[1]), .fifo_rd(rd_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]));
  uart_tx_fifo #(.dat_width(8), .clk_div(4), .parity(2), .stop_bits(2)) d2 (.clk(clk), .reset(reset), .en(en),
    .fifo_empty(empty_v[2]), .fifo_data(data_v[2]), .fifo_rd(rd_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task refresh;
    empty_v = {fq2.size() == 0, fq1.size() == 0, fq0.size() == 0};
    data_v[0] = 8'h00;
    data_v[1] = 8'h00;
    data_v[2] = 8'h00;
    if (fq0.size() > 0) data_v[0] = fq0[0];
    if (fq1.size() > 0) data_v[1] = fq1[0];
    if (fq2.size() > 0) data_v[2] = fq2[0];
  endtask

  task automatic load(input int id, input logic [7:0] d, input bit expect_frame, input logic [11:0] want);
    case (id)
      0: begin fq0.push_back(d); if (expect_frame) eq0.push_back(want); end
      1: begin fq1.push_back(d); if (expect_frame) eq1.push_back(want); end
      default: begin fq2.push_back(d); if (expect_frame) eq2.push_back(want); end
    endcase
    refresh();
  endtask

  function automatic logic [11:0] pop_exp(input int id);
    logic [11:0] w = 12'hFFF;
    case (id)
      0: if (eq0.size() > 0) w = eq0.pop_front();
      1: if (eq1.size() > 0) w = eq1.pop_front();
      default: if (eq2.size() > 0) w = eq2.pop_front();
    endcase
    return w;
  endfunction

  // FIFO model: pops on the edge that sees rd, head word visible after the edge
  initial forever begin
    @(posedge clk);
    if (rd_v[0] === 1'b1 && fq0.size() > 0) void'(fq0.pop_front());
    if (rd_v[1] === 1'b1 && fq1.size() > 0) void'(fq1.pop_front());
    if (rd_v[2] === 1'b1 && fq2.size() > 0) void'(fq2.pop_front());
    #3;
    refresh();
  end

  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) if (rd_v[i] === 1'b1) rd_cnt[i]++;
    if (rd_v[0] === 1'b1) rd_t0.push_back(cyc);
  end

  task automatic mon(input int id);
    int nb;
    logic [11:0] got, want;
    logic cur;
    bit stable, ok_done, ok_rd, ok_busy, aborted;
    nb = 1 + 8 + (id != 0 ? 1 : 0) + (id == 2 ? 2 : 1);
    forever begin
      @(posedge clk);
      #1;
      if (reset !== 1'b1 || tx_v[id] !== 1'b0) continue;
      got = '0; cur = 1'b0; stable = 1; ok_done = 1; ok_rd = 1; ok_busy = 1; aborted = 0;
      for (int j = 0; j < nb * 4; j++) begin
        if (j > 0) begin @(posedge clk); #1; end
        if (reset !== 1'b1) begin aborted = 1; break; end
        if (j % 4 == 0) begin cur = tx_v[id]; got[j/4] = cur; end
        else if (tx_v[id] !== cur) stable = 0;
        if (done_v[id] !== (j == nb * 4 - 1)) ok_done = 0;
        if (rd_v[id] !== (j == 0)) ok_rd = 0;
        if (busy_v[id] !== 1'b1) ok_busy = 0;
      end
      if (aborted) continue;
      want = pop_exp(id);
      chk($sformatf("frame d%0d", id), got, want);
      chk($sformatf("bit_stable d%0d", id), stable, 1);
      chk($sformatf("tx_done_pos d%0d", id), ok_done, 1);
      chk($sformatf("rd_pulse d%0d", id), ok_rd, 1);
      chk($sformatf("busy_frame d%0d", id), ok_busy, 1);
      @(posedge clk);
      #1;
      if (reset === 1'b1) chk($sformatf("idle_gap d%0d", id), {busy_v[id], tx_v[id], done_v[id]}, 3'b010);
    end
  endtask

  initial mon(0);
  initial mon(1);
  initial mon(2);

  task automatic wait_idle(input int id);
    int q = 0;
    for (int i = 0; i < 400 && q < 2; i++) begin
      @(posedge clk);
      #1;
      q = (busy_v[id] === 1'b0) ? q + 1 : 0;
    end
    chk($sformatf("idle_reached d%0d", id), q >= 2, 1);
  endtask

  task automatic wait_rd(input int id);
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = rd_v[id] === 1'b1;
    end
    chk($sformatf("rd_seen d%0d", id), seen, 1);
  endtask

  initial begin
    int c, n;
    reset = 0;
    en = 1;
    refresh();
    load(0, 8'hA5, 1, {1'b1, 8'hA5, 1'b0});
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("reset_hold", {tx_v[0], rd_v[0], busy_v[0]}, 3'b100);
    end
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    chk("first_rd", rd_v[0], 1);
    wait_idle(0);
    chk("single_rd_count", rd_cnt[0], 1);

    @(negedge clk);
    c = rd_cnt[0];
    n = rd_t0.size();
    load(0, 8'h00, 1, {1'b1, 8'h00, 1'b0});
    load(0, 8'hFF, 1, {1'b1, 8'hFF, 1'b0});
    load(0, 8'h3C, 1, {1'b1, 8'h3C, 1'b0});
    wait_idle(0);
    chk("burst_rd_count", rd_cnt[0] - c, 3);
    if (rd_t0.size() >= n + 3) begin
      chk("burst_gap1", rd_t0[n+1] - rd_t0[n], 41);
      chk("burst_gap2", rd_t0[n+2] - rd_t0[n+1], 41);
    end

    @(negedge clk);
    load(0, 8'h11, 1, {1'b1, 8'h11, 1'b0});
    load(0, 8'h22, 1, {1'b1, 8'h22, 1'b0});
    wait_rd(0);
    repeat (18) @(negedge clk);
    en = 0;
    wait_idle(0);
    c = rd_cnt[0];
    repeat (20) @(posedge clk);
    #1;
    chk("no_pop_en_low", rd_cnt[0], c);
    chk("fifo_kept", fq0.size(), 1);
    chk("idle_line_en_low", tx_v[0], 1);
    @(negedge clk);
    en = 1;
    @(posedge clk);
    #1;
    chk("pop_after_en", rd_v[0], 1);
    wait_idle(0);

    @(negedge clk);
    c = rd_cnt[0];
    load(0, 8'h5A, 0, 12'h000);
    load(0, 8'h96, 1, {1'b1, 8'h96, 1'b0});
    wait_rd(0);
    repeat (26) @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
    chk("abort_line", {tx_v[0], busy_v[0], rd_v[0], done_v[0]}, 4'b1000);
    @(negedge clk);
    reset = 1;
    wait_idle(0);
    chk("abort_rd_count", rd_cnt[0] - c, 2);
    chk("abort_fifo_drained", fq0.size(), 0);

    @(negedge clk);
    load(1, 8'h07, 1, {1'b1, 1'b1, 8'h07, 1'b0});
    load(2, 8'h07, 1, {2'b11, 1'b0, 8'h07, 1'b0});
    wait_idle(1);
    wait_idle(2);
    chk("parity_rd_counts", {rd_cnt[1][7:0], rd_cnt[2][7:0]}, 16'h0101);
    repeat (3) @(posedge clk);
    #1;
    chk("frames_left", eq0.size() + eq1.size() + eq2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Serial transmit stage that drains the cyclic transmit FIFO. It sits directly downstream of the FIFO and watches the FIFO's `empty` flag. When data is waiting, it pops one word with a single-cycle `rd` pulse and sends that word as an asynchronous serial frame on `tx`. The FIFO is first-word-fall-through: `data_out` is valid whenever `empty` is low, so this block latches the word in the same cycle it asserts `rd`.

## Interface
Parameters:
- `dat_width`, 8, data bits per frame; must equal the FIFO `dat_width`.
- `clk_div`, 434, clock cycles per serial bit (50 MHz / 115200); legal range 4..65535.
- `parity`, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- `stop_bits`, 1, number of stop bits; 1 or 2.

Ports:
- `clk`, input, 1, system clock; all state changes on the rising edge.
- `reset`, input, 1, synchronous active-low reset, sampled on the rising edge of `clk`.
- `en`, input, 1, enables starting new frames; a frame in progress always completes.
- `fifo_empty`, input, 1, FIFO `empty` flag.
- `fifo_data`, input, `dat_width`, FIFO `data_out` (head word).
- `fifo_rd`, output, 1, one-cycle pop pulse to FIFO `rd`.
- `tx`, output, 1, serial line, idle high.
- `busy`, output, 1, high from start bit to the end of the last stop bit.
- `tx_done`, output, 1, one-cycle pulse in the final cycle of the last stop bit.

## Operation
- State machine states: IDLE, START, DATA, PAR, STOP.
- All outputs are registered.
- Reset (`reset`=0 at an edge): state = IDLE, `tx`=1, `fifo_rd`=0, `busy`=0, `tx_done`=0, counters = 0.
- IDLE: at an edge where `en`=1 and `fifo_empty`=0:
  - latch `fifo_data` into the shift register;
  - go to START with `tx`=0, `busy`=1, `fifo_rd`=1.
- `fifo_rd` is high for exactly one cycle (the first START cycle). It is never high outside that cycle.
- START: `tx`=0 for `clk_div` cycles, then go to DATA.
- DATA: send `dat_width` bits LSB first, each held for `clk_div` cycles.
  - Bit counter width is clog2(`dat_width`+1).
  - After the last bit: go to PAR if `parity`≠0, else go to STOP.
- PAR: hold one bit for `clk_div` cycles.
  - Even mode: XOR of the data bits.
  - Odd mode: inverted XOR of the data bits.
- STOP: `tx`=1 for `stop_bits`×`clk_div` cycles.
  - `tx_done`=1 in the final cycle.
  - Then go to IDLE with `busy`=0.
- Baud counter: counts 0..`clk_div`-1 and wraps to 0 at each bit boundary. Width is 16 bits.
- `en` dropped mid-frame: the current frame finishes normally; no further pops occur.
- `fifo_empty` high in IDLE: the block stays in IDLE with `tx`=1 indefinitely.
- Reset mid-frame: the line returns to `tx`=1 at that edge. The popped word is discarded and is not re-sent.
- `fifo_empty` is ignored outside IDLE.

## Timing
- Start latency: if edge k samples `fifo_empty`=0 in IDLE, then from edge k onward `tx`=0 and `fifo_rd`=1. `fifo_rd` returns to 0 at edge k+1.
- The FIFO updates `empty` by edge k+1. Because `clk_div`≥4, its new `empty` value settles long before the block returns to IDLE, so double pops are impossible.
- Frame length: (1 + `dat_width` + (`parity`≠0) + `stop_bits`) × `clk_div` cycles.
- Back-to-back frames:
  - the block spends one IDLE cycle between the last stop cycle and the next start bit;
  - the gap is therefore `stop_bits`×`clk_div`+1 cycles of high line between data/parity bits;
  - consecutive `fifo_rd` pulses are frame length + 1 cycles apart.
- `tx_done` and the IDLE transition coincide with the end of the last stop-bit cycle.

## Test plan
- Reset: hold `reset`=0 for 3 cycles while `fifo_empty`=0 → `tx`=1, `fifo_rd`=0, `busy`=0 throughout; first `fifo_rd` occurs one edge after release.
- Single byte, `clk_div`=4, `parity`=0, `stop_bits`=1, `fifo_data`=8'hA5 → one `fifo_rd` pulse; `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; `tx_done` once after 40 cycles.
- Burst of 3 words (8'h00, 8'hFF, 8'h3C) preloaded in FIFO → exactly 3 `fifo_rd` pulses spaced 41 cycles apart; received bytes match in order; `busy` drops only after the third frame.
- Parity: `parity`=1 with 8'h07 → parity bit 1; `parity`=2 with 8'h07 → 0; `stop_bits`=2 → stop high for 8 cycles; frame length 48 cycles.
- `en` deasserted at the middle of bit 3 → frame completes, no new `fifo_rd` while FIFO non-empty; re-asserting `en` → pop within 1 cycle.
- Reset asserted during DATA bit 5 → `tx`=1 at the next edge, state IDLE, no `fifo_rd` for the aborted byte; the next FIFO word transmits cleanly after release.
